cpu_trace_buffer: RTL and testbench

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_buffer.sv | 155 +++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of retired-instruction samples around a
// PC trigger. Arm starts capture, a PC match starts a fixed post-trigger
// window, and the held entries are then drained oldest-first.
// Optional feature: define TRACE_DEDUP_EN to drop back-to-back samples that
// repeat the PC of the last written entry.
module cpu_trace_buffer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POST_CNT = 8,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned ENTRY_W = 38 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               sample_valid,
  input  logic [31:0]        pc_in,
  input  logic [5:0]         op_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic [31:0]        trig_pc,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         state,
  output logic [ADDR_W:0]    count,
  output logic               overflow
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PostLoad = ADDR_W'(POST_CNT);
  localparam logic [ADDR_W-1:0] PostLast = ADDR_W'(1);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                overflow_q;
  logic [ADDR_W-1:0]   post_q;
  logic [ENTRY_W-1:0]  mem [DEPTH];

  logic                capturing;
  logic                skip;
  logic                do_write;
  logic                rearm;
  logic                rd_fire;
  logic [ADDR_W-1:0]   rd_idx;

  assign capturing = (state_q == StArmed) || (state_q == StPost);
  assign do_write  = capturing && sample_valid && !skip;
  assign rearm     = arm && ((state_q == StIdle) || (state_q == StDone));
  assign rd_fire   = rd_valid && rd_ready;

`ifdef TRACE_DEDUP_EN
  logic [31:0] last_pc_q;
  logic        last_pc_vld_q;

  // Remember the PC of the most recent written entry since the last arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_vld_q <= 1'b0;
    end else if (rearm) begin
      last_pc_vld_q <= 1'b0;
    end else if (do_write) begin
      last_pc_q     <= pc_in;
      last_pc_vld_q <= 1'b1;
    end
  end

  assign skip = last_pc_vld_q && (pc_in == last_pc_q);
`else
  assign skip = 1'b0;
`endif

  // Capture storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      mem[wr_ptr_q] <= {pc_in, op_in, alu_in};
    end
  end

  // Control FSM: pointer, occupancy, overflow and post-trigger window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      post_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_q    <= StArmed;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        StArmed, StPost: begin
          if (do_write) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            // A full buffer keeps its count; the oldest entry is overwritten.
            if (count_q != DepthCnt) begin
              count_q <= count_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
            if (state_q == StArmed) begin
              if (pc_in == trig_pc) begin
                post_q  <= PostLoad;
                state_q <= StPost;
              end
            end else begin
              post_q <= post_q - 1'b1;
              if (post_q == PostLast) begin
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          // Re-arm discards unread entries and beats a same-cycle read.
          if (arm) begin
            state_q    <= StArmed;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end else if (rd_fire) begin
            count_q <= count_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Oldest entry sits count slots behind the write pointer; at full count the
  // low bits wrap to zero and the index lands on the write pointer itself.
  always_comb begin
    rd_idx   = wr_ptr_q - count_q[ADDR_W-1:0];
    rd_valid = (state_q == StDone) && (count_q != '0);
    rd_data  = rd_valid ? mem[rd_idx] : '0;
  end

  assign state    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: queue-based reference model,
// a per-cycle compare process, directed scenarios and a randomized phase.
module tb_cpu_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int POST  = 8;
  localparam int AW    = 4;
  localparam int EW    = 38 + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          sample_valid = 1'b0;
  logic [31:0]   pc_in = '0;
  logic [5:0]    op_in = '0;
  logic [DW-1:0] alu_in = '0;
  logic [31:0]   trig_pc = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [EW-1:0] rd_data;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          overflow;

  cpu_trace_buffer #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .POST_CNT(POST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .sample_valid(sample_valid),
    .pc_in       (pc_in),
    .op_in       (op_in),
    .alu_in      (alu_in),
    .trig_pc     (trig_pc),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .state       (state),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: held entries as a queue, oldest at index 0.
  logic [EW-1:0] m_q[$];
  int            m_state = 0;
  bit            m_ovf = 1'b0;
  int            m_post = 0;
  bit            m_lastv = 1'b0;
  logic [31:0]   m_last = '0;

`ifdef TRACE_DEDUP_EN
  localparam bit Dedup = 1'b1;
`else
  localparam bit Dedup = 1'b0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ovf   = 1'b0;
    m_lastv = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      m_state = 0;
      m_post  = 0;
      model_clear();
    end else begin
      case (m_state)
        0: if (arm) begin m_state = 1; model_clear(); end
        1, 2: begin
          if (sample_valid && !(Dedup && m_lastv && pc_in == m_last)) begin
            m_q.push_back({pc_in, op_in, alu_in});
            if (m_q.size() > DEPTH) begin
              void'(m_q.pop_front());
              m_ovf = 1'b1;
            end
            m_last  = pc_in;
            m_lastv = 1'b1;
            if (m_state == 1) begin
              if (pc_in == trig_pc) begin
                m_post  = POST;
                m_state = 2;
              end
            end else begin
              m_post--;
              if (m_post == 0) m_state = 3;
            end
          end
        end
        default: begin
          if (arm) begin
            m_state = 1;
            model_clear();
          end else if (rd_ready && m_q.size() > 0) begin
            void'(m_q.pop_front());
          end
        end
      endcase
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic          e_valid;
      logic [EW-1:0] e_data;
      e_valid = (m_state == 3) && (m_q.size() > 0);
      e_data  = e_valid ? m_q[0] : '0;
      chk("state", 128'(state), 128'(m_state));
      chk("count", 128'(count), 128'(m_q.size()));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      chk("rd_valid", 128'(rd_valid), 128'(e_valid));
      chk("rd_data", 128'(rd_data), 128'(e_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic samp(input logic [31:0] pc);
    sample_valid = 1'b1;
    pc_in  = pc;
    op_in  = 6'($urandom);
    alu_in = $urandom;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] tpc);
    trig_pc = tpc;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [31:0] pc26(input int n);
    if (n <= 20) return 32'h1000 + 32'(4 * n);
    if (n == 21) return 32'h50;
    return 32'h2000 + 32'(4 * n);
  endfunction

  function automatic logic [31:0] pc_of(input logic [EW-1:0] e);
    return e[EW-1 -: 32];
  endfunction

  initial begin
    // Reset for two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_data", 128'(rd_data), 128'(0));

    // Trigger at the third sample, then the post window.
    do_arm(32'h08);
    chk("armed_state", 128'(state), 128'(1));
    for (int i = 0; i < 11; i++) samp(32'(4 * i));
    chk("t1_state", 128'(state), 128'(3));
    chk("t1_count", 128'(count), 128'(11));
    chk("t1_ovf", 128'(overflow), 128'(0));
    chk("t1_first_pc", 128'(pc_of(rd_data)), 128'(32'h00));

    // Back-pressure holds the head entry, then drain in write order.
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", 128'(pc_of(rd_data)), 128'(32'h00));
      chk("hold_count", 128'(count), 128'(11));
    end
    for (int i = 0; i < 11; i++) begin
      chk("drain_pc", 128'(pc_of(rd_data)), 128'(4 * i));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("drained_valid", 128'(rd_valid), 128'(0));
    chk("drained_state", 128'(state), 128'(3));
    chk("drained_data", 128'(rd_data), 128'(0));

    // Overflowing pre-trigger history keeps the newest DEPTH samples.
    do_arm(32'h50);
    for (int n = 1; n <= 29; n++) samp(pc26(n));
    chk("ov_state", 128'(state), 128'(3));
    chk("ov_count", 128'(count), 128'(16));
    chk("ov_flag", 128'(overflow), 128'(1));
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) chk("ov_first_pc", 128'(pc_of(rd_data)), 128'(pc26(14)));
      if (i == 15) chk("ov_last_pc", 128'(pc_of(rd_data)), 128'(pc26(29)));
      tick();
    end
    rd_ready = 1'b0;

    // Reset in the middle of the post window.
    do_arm(32'h08);
    for (int i = 0; i < 5; i++) samp(32'(4 * i));
    chk("post_state", 128'(state), 128'(2));
    chk("post_count", 128'(count), 128'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", 128'(state), 128'(0));
    chk("mid_rst_count", 128'(count), 128'(0));
    for (int i = 0; i < 3; i++) samp(32'h08);
    chk("idle_ignore_count", 128'(count), 128'(0));
    chk("idle_ignore_state", 128'(state), 128'(0));

    // Repeated PC on consecutive samples.
    do_arm(32'hFFFF_FFF0);
    for (int i = 0; i < 3; i++) samp(32'h10);
    chk("repeat_count", 128'(count), Dedup ? 128'(1) : 128'(3));

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      arm          = ($urandom_range(0, 24) == 0);
      if (arm) trig_pc = 32'(4 * $urandom_range(0, 7));
      sample_valid = ($urandom_range(0, 2) != 0);
      pc_in        = 32'(4 * $urandom_range(0, 7));
      op_in        = 6'($urandom);
      alu_in       = $urandom;
      rd_ready     = ($urandom_range(0, 1) == 1);
      tick();
    end
    rst = 1'b0;
    arm = 1'b0;
    sample_valid = 1'b0;
    rd_ready = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
